generic_fifo_reader: RTL and testbench
======================================

// Module: generic_fifo_reader
// PURPOSE
//  Consumer-side controller for generic_fifo: pops words via read/empty and captures the registered read_data.
//  Re-presents them as a valid/ready stream to a downstream block, with a 3-entry elastic buffer.
//  Sustains one word per cycle with no combinational path from out_ready to fifo_read.
//  Sits between any generic_fifo instance and a consumer that may stall.
// PARAMETERS
//  GENERIC_FIFO_DATA_WIDTH  32  width of fifo_read_data / out_data
//  XFER_COUNT_WIDTH         16  width of xfer_count (wraps modulo 2^XFER_COUNT_WIDTH)
// PORTS
//  clk              in   1      clock; all state on posedge
//  reset_poweron    in   1      synchronous, active-high reset
//  clear            in   1      synchronous flush of local state (fifo clears itself on same signal)
//  read_enable      in   1      1 = allowed to pop fifo; 0 = stop issuing new fifo_read
//  fifo_empty       in   1      generic_fifo empty
//  fifo_read        out  1      pop strobe to generic_fifo (combinational from local state + fifo_empty)
//  fifo_read_data   in   DW     generic_fifo read_data, valid the cycle after fifo_read
//  out_valid        out  1      head of elastic buffer valid (registered)
//  out_ready        in   1      downstream accepts out_data when out_valid & out_ready
//  out_data         out  DW     head word (registered)
//  xfer_count       out  XCW    number of completed out_valid&out_ready handshakes
//  busy             out  1      1 when buf_cnt!=0 or inflight
// BEHAVIOUR
//  State: buf[0:2] (DW each), rd_ptr/wr_ptr (2b, wrap 2->0), buf_cnt (0..3), inflight (1b), xfer_count.
//  Reset (reset_poweron=1): buf_cnt=0, ptrs=0, inflight=0, xfer_count=0.
//    Outputs: out_valid=0, out_data=0, fifo_read=0, busy=0. Reset overrides clear and all inputs.
//  fifo_read = ~reset_poweron & ~clear & read_enable & ~fifo_empty & ((buf_cnt + inflight) < 3).
//    Never reads an empty fifo. Never depends on out_ready.
//  inflight <= fifo_read. Capture: when inflight=1, buf[wr_ptr] <= fifo_read_data; wr_ptr++.
//    fifo_read_data is sampled only when inflight=1; its held value is ignored otherwise.
//  pop = out_valid & out_ready. On pop: rd_ptr++, xfer_count++ (wraps).
//  buf_cnt <= buf_cnt + inflight - pop. Capture and pop in the same cycle leave buf_cnt unchanged.
//  out_valid = (buf_cnt != 0); out_data = buf[rd_ptr]. Both are driven from registers only.
//  out_data holds its value while out_valid & ~out_ready (no change under stall).
//  Latency: fifo_read at cycle N -> word in buf end of N+1 -> out_valid/out_data at N+2.
//  Throughput: steady state buf_cnt=1, inflight=1 -> fifo_read every cycle, one pop per cycle.
//  Credit rule: buf_cnt + inflight <= 3 always, so a captured word never finds the buffer full (no overflow).
//  read_enable=0: no new fifo_read; an inflight word is still captured; buffered words still drain.
//  clear=1: buf_cnt=0, ptrs=0, inflight=0 next cycle. Any word returning that cycle is discarded.
//    out_valid=0 from the next cycle. xfer_count is NOT cleared (only reset clears it).
//  clear and pop in the same cycle: the pop completes (counted); the rest is flushed.
//  Ordering: words leave in exactly the order popped from the fifo; no duplication, no loss except on clear/reset.
// TESTING
//  1 Reset: hold reset_poweron 2 cycles with fifo_empty=0 -> fifo_read=0, out_valid=0, out_data=0, xfer_count=0.
//  2 Streaming: fifo holds 0x10..0x17, read_enable=1, out_ready=1 -> fifo_read for 8 consecutive cycles;
//    out_valid for 8 consecutive cycles starting 2 cycles after the first fifo_read, data 0x10..0x17; xfer_count=8.
//  3 Backpressure: out_ready=0 with 8 words available -> exactly 3 fifo_read pulses, buf_cnt=3, out_data=0x10 held;
//    release out_ready -> 0x10..0x17 in order, no gaps after the first.
//  4 Empty boundary: fifo goes empty after 0x20 -> fifo_read=0 while fifo_empty=1, out_valid drops after 0x20;
//    refill with 0x21 -> delivered 2 cycles after its fifo_read.
//  5 Clear mid-flight: 2 words buffered + 1 inflight, assert clear 1 cycle ->
//    out_valid=0 next cycle; xfer_count unchanged; the next word written is the first delivered.
//  6 Pause: read_enable=0 while inflight=1 -> that word is captured and delivered; no further fifo_read until read_enable=1.

Source files
------------

// File: rtl/generic_fifo_reader.sv
// Consumer-side reader for generic_fifo: pops words with credit-based flow control
// and re-presents them as a valid/ready stream from a 3-entry elastic buffer.
module generic_fifo_reader #(
    parameter int unsigned GENERIC_FIFO_DATA_WIDTH = 32,
    parameter int unsigned XFER_COUNT_WIDTH        = 16
) (
    input  logic                               clk,
    input  logic                               reset_poweron,
    input  logic                               clear,
    input  logic                               read_enable,
    input  logic                               fifo_empty,
    output logic                               fifo_read,
    input  logic [GENERIC_FIFO_DATA_WIDTH-1:0] fifo_read_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [GENERIC_FIFO_DATA_WIDTH-1:0] out_data,
    output logic [XFER_COUNT_WIDTH-1:0]        xfer_count,
    output logic                               busy
);

    logic [GENERIC_FIFO_DATA_WIDTH-1:0] buf_mem [0:2];
    logic [1:0]                         rd_ptr;
    logic [1:0]                         wr_ptr;
    logic [1:0]                         buf_cnt;
    logic                               inflight;
    logic                               pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts the word already requested, so a returning word always has a slot.
    always_comb begin
        fifo_read = ~reset_poweron & ~clear & read_enable & ~fifo_empty &
                    (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd3);
    end

    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = out_valid ? buf_mem[rd_ptr] : '0;
    assign pop       = out_valid & out_ready;
    assign busy      = out_valid | inflight;

    always_ff @(posedge clk) begin
        if (inflight && !clear && !reset_poweron) begin
            buf_mem[wr_ptr] <= fifo_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            buf_cnt    <= '0;
            inflight   <= 1'b0;
            xfer_count <= '0;
        end else if (clear) begin
            // A handshake in the clearing cycle still completes and is counted.
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            buf_cnt  <= '0;
            inflight <= 1'b0;
            if (pop) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end else begin
            inflight <= fifo_read;
            if (inflight) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr     <= ptr_next(rd_ptr);
                xfer_count <= xfer_count + 1'b1;
            end
            buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_generic_fifo_reader.sv
// Self-checking bench for generic_fifo_reader: behavioural generic_fifo model feeding the
// DUT, scoreboard queue of expected output words, and per-phase timing counters.
module tb_generic_fifo_reader;

    localparam int unsigned DW  = 32;
    localparam int unsigned XCW = 16;

    logic           clk = 1'b0;
    logic           reset_poweron;
    logic           clear;
    logic           read_enable;
    logic           fifo_empty;
    logic           fifo_read;
    logic [DW-1:0]  fifo_read_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [XCW-1:0] xfer_count;
    logic           busy;

    generic_fifo_reader #(
        .GENERIC_FIFO_DATA_WIDTH(DW),
        .XFER_COUNT_WIDTH(XCW)
    ) dut (
        .clk(clk),
        .reset_poweron(reset_poweron),
        .clear(clear),
        .read_enable(read_enable),
        .fifo_empty(fifo_empty),
        .fifo_read(fifo_read),
        .fifo_read_data(fifo_read_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .xfer_count(xfer_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fq[$];     // contents of the modelled generic_fifo
    logic [DW-1:0] exp_q[$];  // expected output order

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_rd, first_rd, last_rd, rd_empty;
    int n_val, first_val, last_val;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic phase_reset();
        n_rd = 0; first_rd = -1; last_rd = -1; rd_empty = 0;
        n_val = 0; first_val = -1; last_val = -1;
    endtask

    task automatic load(input logic [DW-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample DUT before the edge, then update the fifo model after it.
    task automatic tick();
        logic rd, clr;
        logic [DW-1:0] w;
        #1;
        cyc++;
        if (fifo_read) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (fifo_empty) rd_empty++;
        end
        if (out_valid) begin
            n_val++;
            if (first_val < 0) first_val = cyc;
            last_val = cyc;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_extra_word", 64'(exp_q.size()), 64'd1);
            else begin
                w = exp_q.pop_front();
                check("sb_data", 64'(out_data), 64'(w));
            end
        end
        rd  = fifo_read;
        clr = clear;
        @(posedge clk);
        #1;
        if (clr) begin
            fq.delete();
            exp_q.delete();
        end else if (rd) begin
            fifo_read_data = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input string tag, input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && fq.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 64'(done), 64'd1);
    endtask

    initial begin
        reset_poweron  = 1'b1;
        clear          = 1'b0;
        read_enable    = 1'b1;
        out_ready      = 1'b1;
        fifo_read_data = 32'hDEAD_BEEF;
        fifo_empty     = 1'b1;
        phase_reset();

        // Reset with a non-empty fifo
        fq.push_back(32'hAA);
        fifo_empty = 1'b0;
        run(2);
        check("rst_fifo_read", 64'(fifo_read), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_xfer_count", 64'(xfer_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        fq.delete();
        fifo_empty    = 1'b1;
        reset_poweron = 1'b0;
        tick();

        // Streaming
        phase_reset();
        for (int i = 0; i < 8; i++) load(32'h10 + 32'(i));
        drain("stream_drain", 40);
        check("stream_reads", 64'(n_rd), 64'd8);
        check("stream_read_span", 64'(last_rd - first_rd), 64'd7);
        check("stream_latency", 64'(first_val - first_rd), 64'd2);
        check("stream_valids", 64'(n_val), 64'd8);
        check("stream_valid_span", 64'(last_val - first_val), 64'd7);
        check("stream_xfer", 64'(xfer_count), 64'd8);

        // Backpressure
        phase_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(32'h10 + 32'(i));
        run(10);
        check("bp_reads", 64'(n_rd), 64'd3);
        check("bp_fifo_left", 64'(fq.size()), 64'd5);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_held_data", 64'(out_data), 64'h10);
        check("bp_xfer", 64'(xfer_count), 64'd8);
        phase_reset();
        out_ready = 1'b1;
        drain("bp_drain", 40);
        check("bp_valids", 64'(n_val), 64'd8);
        check("bp_no_gaps", 64'(last_val - first_val), 64'd7);
        check("bp_xfer_after", 64'(xfer_count), 64'd16);

        // Empty boundary
        phase_reset();
        load(32'h20);
        drain("empty_drain", 20);
        run(4);
        check("empty_reads", 64'(n_rd), 64'd1);
        check("empty_no_read", 64'(rd_empty), 64'd0);
        check("empty_valid_low", 64'(out_valid), 64'd0);
        phase_reset();
        load(32'h21);
        drain("refill_drain", 20);
        check("refill_latency", 64'(first_val - first_rd), 64'd2);
        check("refill_xfer", 64'(xfer_count), 64'd18);

        // Clear with 2 buffered + 1 inflight
        phase_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(32'h30 + 32'(i));
        run(3);
        check("clr_pre_reads", 64'(n_rd), 64'd3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid_low", 64'(out_valid), 64'd0);
        check("clr_busy_low", 64'(busy), 64'd0);
        check("clr_xfer_kept", 64'(xfer_count), 64'd18);
        out_ready = 1'b1;
        load(32'h40);
        drain("clr_drain", 20);
        check("clr_xfer_after", 64'(xfer_count), 64'd19);

        // Pause while a word is inflight
        phase_reset();
        for (int i = 0; i < 4; i++) load(32'h50 + 32'(i));
        tick();
        check("pause_first_read", 64'(n_rd), 64'd1);
        read_enable = 1'b0;
        phase_reset();
        run(6);
        check("pause_reads", 64'(n_rd), 64'd0);
        check("pause_delivered", 64'(n_val), 64'd1);
        check("pause_fifo_left", 64'(fq.size()), 64'd3);
        read_enable = 1'b1;
        drain("pause_drain", 20);
        check("pause_xfer", 64'(xfer_count), 64'd23);
        check("sb_empty_end", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
